// File: rtl/dvp_pkg.sv
// Shared types and default geometry for the DVP transmit path.
package dvp_pkg;

    localparam int DATA_W = 8;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_BLANK     = 160;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } dvp_tx_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Line/frame counters and the frame state machine for the DVP transmitter.
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic          dvp_pclk,
    input  logic          rst,
    input  logic          tx_enable,
    output dvp_tx_state_t state,
    output logic          line_end,
    output logic          last_line,
    output logic          active_byte
);

    localparam int L     = H_ACTIVE + H_BLANK;
    localparam int V_MAX = max_of(max_of(V_ACTIVE, VSYNC_LINES),
                                  max_of(V_BACK, V_FRONT));
    localparam int HW    = $clog2(L);
    localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_last;

    always_comb begin
        v_last = '0;
        unique case (state)
            VSYNC:   v_last = VW'(VSYNC_LINES - 1);
            VBACK:   v_last = VW'(V_BACK - 1);
            ACTIVE:  v_last = VW'(V_ACTIVE - 1);
            VFRONT:  v_last = VW'(V_FRONT - 1);
            default: v_last = '0;
        endcase
    end

    assign line_end    = (state != IDLE) && (h_cnt == HW'(L - 1));
    assign last_line   = (v_cnt == v_last);
    assign active_byte = (state == ACTIVE) && (h_cnt < HW'(H_ACTIVE));

    always_ff @(posedge dvp_pclk) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (tx_enable) state <= VSYNC;
        end else if (line_end) begin
            h_cnt <= '0;
            if (last_line) begin
                v_cnt <= '0;
                unique case (state)
                    VSYNC:   state <= VBACK;
                    VBACK:   state <= ACTIVE;
                    ACTIVE:  state <= VFRONT;
                    default: state <= tx_enable ? VSYNC : IDLE;
                endcase
            end else begin
                v_cnt <= v_cnt + VW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/dvp_transmit.sv
// DVP source: pops FIFO bytes into registered vsync/href/data timing.
module dvp_transmit
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic              dvp_pclk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic [DATA_W-1:0] dvp_data,
    output logic              dvp_href,
    output logic              dvp_vsync,
    output logic              frame_done,
    output logic              underflow
);

    dvp_tx_state_t state;
    logic          line_end;
    logic          last_line;
    logic          active_byte;
    logic          frame_end;
    logic          frame_start;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .dvp_pclk    (dvp_pclk),
        .rst         (rst),
        .tx_enable   (tx_enable),
        .state       (state),
        .line_end    (line_end),
        .last_line   (last_line),
        .active_byte (active_byte)
    );

    assign frame_end   = (state == VFRONT) && line_end && last_line;
    assign frame_start = tx_enable && ((state == IDLE) || frame_end);
    assign fifo_read   = active_byte && !fifo_empty;

    // Outputs lag the state by one edge, so all timing relations hold.
    always_ff @(posedge dvp_pclk) begin
        if (rst) begin
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= '0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dvp_vsync  <= (state == VSYNC);
            dvp_href   <= active_byte;
            dvp_data   <= fifo_read ? fifo_data : '0;
            frame_done <= frame_end;
            if (frame_start)
                underflow <= 1'b0;
            else if (active_byte && fifo_empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: doc/dvp_transmit.md
# dvp_transmit

Transmit-side DVP timing generator. Pops pixel bytes from a first-word-fall-through FIFO and drives `dvp_vsync`, `dvp_href` and `dvp_data` on `dvp_pclk` with parameterised frame geometry. Frame start is marked by a `vsync` falling edge, and `href` is high for exactly one line of bytes. Used as a camera-side source for loopback tests of the capture path and as the output stage toward external DVP sinks.

## Interface
- `H_ACTIVE`, default 640: bytes per line (`href` high cycles), ≥1
- `H_BLANK`, default 160: `href`-low cycles after each line, ≥1
- `V_ACTIVE`, default 480: lines carrying data, ≥1
- `VSYNC_LINES`, default 3: lines with `vsync` high, ≥1
- `V_BACK`, default 17: blank lines between `vsync` fall and the first active line, ≥1
- `V_FRONT`, default 10: blank lines after the last active line, ≥1
- `dvp_pclk  in  1`: sole clock; all logic is on the rising edge
- `rst  in  1`: synchronous, active-high reset
- `tx_enable  in  1`: permits starting a new frame
- `fifo_data  in  8`: FIFO head byte; valid whenever `fifo_empty` = 0
- `fifo_empty  in  1`: FIFO empty flag
- `fifo_read  out  1`: pop strobe (combinational)
- `dvp_data  out  8`: pixel byte (registered)
- `dvp_href  out  1`: line valid (registered)
- `dvp_vsync  out  1`: frame sync, active-high pulse (registered)
- `frame_done  out  1`: one-cycle pulse at the end of each frame
- `underflow  out  1`: sticky flag; FIFO was empty during an active byte

## Operation
- States and transitions:
  - IDLE → VSYNC when `tx_enable` = 1.
  - VSYNC → VBACK → ACTIVE → VFRONT, each after its parameterised line count.
  - VFRONT → VSYNC if `tx_enable` = 1, otherwise → IDLE.
- Line length is L = `H_ACTIVE` + `H_BLANK`.
- `h_cnt` runs 0..L-1 in every non-IDLE state. `v_cnt` counts lines within a state and clears on each state change.
- `dvp_vsync` is 1 in VSYNC, 0 elsewhere. The falling edge at VSYNC→VBACK is the frame start.
- In ACTIVE, `h_cnt` < `H_ACTIVE` is an active byte:
  - `fifo_read` = active byte & !`fifo_empty`.
  - At the same edge: `dvp_href` ← 1 and `dvp_data` ← `fifo_data`.
- If `fifo_empty` = 1 on an active byte:
  - No pop.
  - `dvp_href` ← 1 still, and `dvp_data` ← 0x00.
  - `underflow` ← 1.
  - Geometry is never stretched.
- Outside active bytes: `dvp_href` ← 0, `dvp_data` ← 0x00.
- `underflow` clears on reset or at VSYNC entry.
- `frame_done` pulses on the last cycle of the last VFRONT line.
- Deasserting `tx_enable` mid-frame does not abort the frame; it completes, then the block enters IDLE.
- Counter widths are `$clog2(max+1)`. Wrap is exact at L-1 and at each state's line count minus 1.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset is honoured mid-frame at the next edge, regardless of state.
- `fifo_data` → `dvp_data` latency: 1 cycle, aligned with `dvp_href`. The pop and the `href`-rising edge fall on the same clock edge.
- IDLE → first `vsync` high: 1 cycle after `tx_enable` is sampled high.
- Frame period: L × (`VSYNC_LINES` + `V_BACK` + `V_ACTIVE` + `V_FRONT`) cycles. Back-to-back frames have no gap.
- `vsync` fall → first `href` high: `V_BACK` × L cycles.
- `href` is high for exactly `H_ACTIVE` consecutive cycles per active line, `V_ACTIVE` times per frame.
- `vsync` and `href` are never high together.
- `tx_enable` and `fifo_empty` are not sampled outside their stated states.
- `fifo_empty` rising on the same cycle as a pop: that pop is not issued.

## Structure
- Package `dvp_pkg` holds:
  - state enum `dvp_tx_state_t` (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - default geometry constants;
  - the byte width constant (8).
- Sub-module `dvp_timing_gen` holds the `h_cnt`/`v_cnt` counters and the state machine. It outputs `line_end`, `active_byte` and state.
- The top level adds the FIFO pop, the output registers and the flags.

## Test plan
Unless noted, use `H_ACTIVE`=4, `H_BLANK`=2, `V_ACTIVE`=3, `VSYNC_LINES`=1, `V_BACK`=1, `V_FRONT`=1, so L = 6 and the frame is 36 cycles.

- Reset: hold `rst` for 3 cycles with `tx_enable` = 1 → all outputs 0. `vsync` rises 1 cycle after release.
- Full frame, FIFO preloaded with 0x01..0x0C:
  - `vsync` high for 6 cycles.
  - `href` rises 6 cycles after the `vsync` fall.
  - 3 bursts: 01-04, 05-08, 09-0C, each followed by 2 low cycles.
  - `frame_done` on cycle 36.
  - Exactly 12 `fifo_read` pulses.
- Underflow: FIFO holds 6 bytes →
  - bytes 7-12 output as 0x00 with `href` still high;
  - `underflow` = 1 from the 7th byte;
  - `underflow` cleared at the next VSYNC.
- `tx_enable` dropped in the ACTIVE state → the frame completes, `frame_done` pulses, the block returns to IDLE, and no further `vsync` occurs.
- Back-to-back frames with `tx_enable` held high → the second `vsync` rises on the cycle after `frame_done`, and the period is 36.
- Reset asserted during the second active line → all outputs 0 on the next edge, and the block restarts cleanly from IDLE.
